// File: rtl/mem_handshake_ram.sv
// Byte-organised little-endian RAM behind a four-phase MFA/MFC handshake.
// Each access is latched in IDLE, waits WAIT_STATES cycles, commits once on
// entry to DONE and holds MFC until MFA is seen low.
// Optional build macro: MEM_ALIGN_CHECK_EN flags misaligned word accesses with
// Error (no write, DataOut kept); when undefined the low address bits are dropped.
module mem_handshake_ram #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              READ_WRITE,
    input  logic              WORD_BYTE,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MFC,
    output logic              Error
);

    localparam int unsigned       NBYTES     = DATA_W / 8;
    localparam int unsigned       DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBYTES - 1);
    localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_rw;
    logic              r_wb;
    logic [DATA_W-1:0] r_dout;
    logic              r_mfc;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH];

    logic              w_start;
    logic              w_commit;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_rw;
    logic              w_wb;
    logic [ADDR_W-1:0] w_base;
    logic              w_misalign;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rdata;

    assign w_start = (r_state == StIdle) && MFA;

    // With zero wait states the access commits on the sampling edge itself,
    // so the operands come straight from the ports instead of the latches.
    assign w_commit = (w_start && (WAIT_STATES == 0)) ||
                      ((r_state == StWait) && (r_cnt == 4'd1));
    assign w_addr   = (r_state == StIdle) ? Address    : r_addr;
    assign w_data   = (r_state == StIdle) ? DataIn     : r_data;
    assign w_rw     = (r_state == StIdle) ? READ_WRITE : r_rw;
    assign w_wb     = (r_state == StIdle) ? WORD_BYTE  : r_wb;

    // Word base is aligned, so base + byte index never wraps inside a word.
    assign w_base = w_addr & ~ALIGN_MASK;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_wb && (|(w_addr & ALIGN_MASK));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_wr_en = w_commit && !w_rw && !w_misalign;
    assign w_rd_en = w_commit &&  w_rw && !w_misalign;

    // Assemble read data: little-endian word or zero-extended single byte.
    always_comb begin
        w_rdata = '0;
        if (w_wb) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                w_rdata[8*i +: 8] = r_mem[w_base + ADDR_W'(i)];
            end
        end else begin
            w_rdata[7:0] = r_mem[w_addr];
        end
    end

    // Storage has no reset; a write is suppressed while Reset is high.
    always_ff @(posedge Clk) begin
        if (w_wr_en && !Reset) begin
            if (w_wb) begin
                for (int i = 0; i < int'(NBYTES); i++) begin
                    r_mem[w_base + ADDR_W'(i)] <= w_data[8*i +: 8];
                end
            end else begin
                r_mem[w_addr] <= w_data[7:0];
            end
        end
    end

    // Handshake FSM with registered MFC, Error and DataOut.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rw    <= 1'b0;
            r_wb    <= 1'b0;
            r_dout  <= '0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (MFA) begin
                        r_addr <= Address;
                        r_data <= DataIn;
                        r_rw   <= READ_WRITE;
                        r_wb   <= WORD_BYTE;
                        r_cnt  <= WAIT_INIT;
                        if (WAIT_STATES == 0) begin
                            r_state <= StDone;
                            r_mfc   <= 1'b1;
                            r_err   <= w_misalign;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    // MFA is ignored here: a started access always completes.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= StDone;
                        r_mfc   <= 1'b1;
                        r_err   <= w_misalign;
                    end
                end
                StDone: begin
                    if (!MFA) begin
                        r_state <= StIdle;
                        r_mfc   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_rd_en) begin
                r_dout <= w_rdata;
            end
        end
    end

    assign DataOut = r_dout;
    assign MFC     = r_mfc;
    assign Error   = r_err;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Bench for mem_handshake_ram: transaction-level memory model with a per-cycle
// compare on the default instance, plus literal checks on a zero-wait instance.
module tb_mem_handshake_ram;

    localparam int WS = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit AlignChk = 1'b1;
`else
    localparam bit AlignChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mfa, rw, wb;
    logic [7:0]  addr;
    logic [31:0] din, dout;
    logic        mfc, err;
    logic        mfa1, rw1, wb1;
    logic [7:0]  addr1;
    logic [31:0] din1, dout1;
    logic        mfc1, err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_handshake_ram #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(WS)) u_dut (
        .Clk(clk), .Reset(rst), .MFA(mfa), .READ_WRITE(rw), .WORD_BYTE(wb),
        .Address(addr), .DataIn(din), .DataOut(dout), .MFC(mfc), .Error(err)
    );

    mem_handshake_ram #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .Clk(clk), .Reset(rst), .MFA(mfa1), .READ_WRITE(rw1), .WORD_BYTE(wb1),
        .Address(addr1), .DataIn(din1), .DataOut(dout1), .MFC(mfc1), .Error(err1)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: an access completes WS+1 edges after sampling (sampling edge counts
    // as the first), then MFC stays high until an edge sees MFA low.
    logic [7:0]  mm [256];
    bit          m_busy, m_hold;
    int          m_age;
    logic        m_rw, m_wb;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] exp_dout = '0;
    logic        exp_mfc  = 1'b0;
    logic        exp_err  = 1'b0;

    task automatic model_commit();
        logic [7:0] base;
        base = m_addr & 8'hFC;
        if (m_wb && (m_addr[1:0] != 2'b00) && AlignChk) begin
            exp_err = 1'b1;
        end else if (m_rw) begin
            if (m_wb) exp_dout = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
            else      exp_dout = {24'h0, mm[m_addr]};
        end else if (m_wb) begin
            for (int i = 0; i < 4; i++) mm[base + 8'(i)] = m_data[8*i +: 8];
        end else begin
            mm[m_addr] = m_data[7:0];
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_hold = 0;
            exp_mfc = 0; exp_err = 0; exp_dout = '0;
        end else if (m_hold) begin
            if (!mfa) begin
                m_hold = 0; exp_mfc = 0; exp_err = 0;
            end
        end else begin
            if (!m_busy && mfa) begin
                m_busy = 1; m_age = 0;
                m_rw = rw; m_wb = wb; m_addr = addr; m_data = din;
            end
            if (m_busy) begin
                m_age++;
                if (m_age == WS + 1) begin
                    m_busy = 0; m_hold = 1; exp_mfc = 1;
                    model_commit();
                end
            end
        end
    end

    // Per-cycle compare of the default instance against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (mfc !== exp_mfc || err !== exp_err || dout !== exp_dout) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual mfc=%b err=%b dout=%h required mfc=%b err=%b dout=%h",
                         $time, mfc, err, dout, exp_mfc, exp_err, exp_dout);
            end
        end
    end

    // One full handshake; lat = edges from sampling edge (inclusive) to MFC.
    task automatic access(input bit rd, input bit wd, input logic [7:0] a, input logic [31:0] d,
                          input bit drop_early, output logic [31:0] q, output int lat,
                          output logic e);
        @(negedge clk);
        mfa = 1; rw = rd; wb = wd; addr = a; din = d;
        lat = 0; q = '0; e = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Post-latch garbage must be ignored.
                addr = ~a; din = ~d; rw = ~rd; wb = ~wd;
                if (drop_early) mfa = 0;
            end
            if (mfc) begin
                lat = k; q = dout; e = err;
            end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL mfc_timeout actual=0 required=1");
        end
        mfa = 0;
        for (int k = 0; k < 10 && mfc; k++) @(negedge clk);
        if (mfc) begin
            checks++; failures++;
            $display("FAIL mfc_release actual=1 required=0");
        end
    endtask

    logic [31:0] q;
    int          lat;
    logic        e;

    initial begin
        mfa = 0; rw = 0; wb = 0; addr = '0; din = '0;
        mfa1 = 0; rw1 = 0; wb1 = 0; addr1 = '0; din1 = '0;
        rst = 0;
        #1 rst = 1;
        #1;
        check32("reset_dout", dout, 32'h0);
        check32("reset_mfc", {31'h0, mfc}, 32'h0);
        check32("reset_err", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;

        access(0, 1, 8'h10, 32'hDEADBEEF, 0, q, lat, e);
        check32("wr_word_latency", lat, 3);
        access(1, 1, 8'h10, 32'h0, 0, q, lat, e);
        check32("rd_word_latency", lat, 3);
        check32("rd_word_0x10", q, 32'hDEADBEEF);
        access(1, 0, 8'h11, 32'h0, 0, q, lat, e);
        check32("rd_byte_0x11", q, 32'h000000BE);
        access(0, 0, 8'h12, 32'hAABBCC55, 0, q, lat, e);
        access(1, 1, 8'h10, 32'h0, 0, q, lat, e);
        check32("rd_word_after_byte_wr", q, 32'hDE55BEEF);

        // MFA dropped during WAIT: the write still completes.
        access(0, 0, 8'h13, 32'h00000077, 1, q, lat, e);
        access(1, 1, 8'h10, 32'h0, 0, q, lat, e);
        check32("rd_word_after_early_drop", q, 32'h7755BEEF);

        // Reset mid-WAIT cancels a write.
        access(0, 1, 8'h20, 32'hCAFEF00D, 0, q, lat, e);
        @(negedge clk);
        mfa = 1; rw = 0; wb = 1; addr = 8'h20; din = 32'h12345678;
        @(negedge clk);
        #2 rst = 1;
        #1;
        check32("reset_midwait_mfc", {31'h0, mfc}, 32'h0);
        check32("reset_midwait_dout", dout, 32'h0);
        mfa = 0;
        @(negedge clk);
        rst = 0;
        access(1, 1, 8'h20, 32'h0, 0, q, lat, e);
        check32("rd_after_cancelled_wr", q, 32'hCAFEF00D);

        // Misaligned word write.
        access(0, 1, 8'h21, 32'h11223344, 0, q, lat, e);
        check32("misaligned_err", {31'h0, e}, {31'h0, AlignChk});
        access(1, 1, 8'h20, 32'h0, 0, q, lat, e);
        check32("rd_after_misaligned_wr", q, AlignChk ? 32'hCAFEF00D : 32'h11223344);
        check32("rd_after_misaligned_err", {31'h0, e}, 32'h0);

        // Zero-wait instance: immediate MFC, held MFA starts nothing new.
        @(negedge clk);
        mfa1 = 1; rw1 = 0; wb1 = 1; addr1 = 8'h40; din1 = 32'h0BADF00D;
        @(negedge clk);
        check32("ws0_mfc_first_edge", {31'h0, mfc1}, 32'h1);
        din1 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check32("ws0_mfc_held", {31'h0, mfc1}, 32'h1);
        end
        mfa1 = 0;
        @(negedge clk);
        check32("ws0_mfc_cleared", {31'h0, mfc1}, 32'h0);
        @(negedge clk);
        mfa1 = 1; rw1 = 1;
        @(negedge clk);
        check32("ws0_rd_mfc", {31'h0, mfc1}, 32'h1);
        check32("ws0_rd_data", dout1, 32'h0BADF00D);
        mfa1 = 0;
        @(negedge clk);
        check32("ws0_rd_mfc_cleared", {31'h0, mfc1}, 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_handshake_ram.md
MEM_HANDSHAKE_RAM -- requirements
Module: mem_handshake_ram

Interface
REQ-001 Parameter DATA_W, default 32: data-bus width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ADDR_W, default 8: byte-address width; storage depth SHALL be 2**ADDR_W bytes.
REQ-003 Parameter WAIT_STATES, default 2, range 0-15: extra cycles inserted before MFC.
REQ-004 Port Clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port Reset  input  1: asynchronous, active-high reset.
REQ-006 Port MFA  input  1: memory-function-active request from the control unit.
REQ-007 Port READ_WRITE  input  1: 1 = read, 0 = write.
REQ-008 Port WORD_BYTE  input  1: 1 = word access (DATA_W/8 bytes), 0 = byte access.
REQ-009 Port Address  input  ADDR_W: byte address.
REQ-010 Port DataIn  input  DATA_W: write data; byte writes use DataIn[7:0].
REQ-011 Port DataOut  output  DATA_W: read data, registered.
REQ-012 Port MFC  output  1: memory-function-complete acknowledge, registered.
REQ-013 Port Error  output  1: misaligned-access flag, registered; see REQ-030.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, and DONE.
REQ-015 IDLE with MFA=1 at a clock edge SHALL latch Address, DataIn, READ_WRITE, and WORD_BYTE, and load the wait counter with WAIT_STATES.
- Next state: WAIT if WAIT_STATES>0, else DONE.
REQ-016 WAIT SHALL decrement the counter each cycle.
- Counter reaching 0 SHALL perform the access and enter DONE on that edge.
REQ-017 Entry to DONE SHALL set MFC=1, so MFC rises exactly WAIT_STATES+1 cycles after the sampling edge.
REQ-018 DONE SHALL hold MFC=1 and DataOut stable while MFA=1.
- MFA=0 sampled in DONE SHALL clear MFC and return to IDLE on that edge (full four-phase handshake).
REQ-019 Input changes after the latching edge SHALL be ignored until the next IDLE.
- MFA dropping during WAIT SHALL NOT abort the access.
REQ-020 Storage SHALL be byte-organised and little-endian.
- Word access covers bytes A..A+DATA_W/8-1, least significant byte at the lowest address.
REQ-021 Word address SHALL be Address with log2(DATA_W/8) LSBs cleared; when DATA_W=8, word and byte accesses are identical.
REQ-022 Byte read SHALL return the byte zero-extended in DataOut.
- Byte write SHALL modify exactly one byte.
REQ-023 Writes SHALL leave DataOut unchanged.
- Each access SHALL commit exactly once, on the transition into DONE.
REQ-024 MFA held high across DONE->IDLE SHALL NOT start a new access.
- The return to IDLE forces MFA=0 to be seen first, so back-to-back accesses need at least one MFA-low cycle.
REQ-025 Address arithmetic SHALL NOT wrap inside a word because of the alignment in REQ-021.

Reset
REQ-026 Reset=1 SHALL immediately force state IDLE, MFC=0, DataOut=0, Error=0, and counter=0, independent of Clk.
REQ-027 Reset asserted during WAIT SHALL cancel the access; no byte SHALL be written.
REQ-028 Reset SHALL NOT clear storage contents.
REQ-029 The first access SHALL be sampled no earlier than the first rising edge after Reset deasserts.

Configuration
REQ-030 Macro MEM_ALIGN_CHECK_EN SHALL select misaligned-word handling.
- Defined: a word access with nonzero alignment LSBs SHALL still complete the handshake, SHALL set Error=1 with MFC, SHALL write nothing, and SHALL leave DataOut unchanged. Error SHALL clear with MFC.
- Undefined: Error SHALL be constant 0, and misaligned LSBs SHALL be silently ignored per REQ-021.

Verification
REQ-031 Defaults: write word 0xDEADBEEF at 0x10, then read word at 0x10 -> DataOut=0xDEADBEEF, with MFC rising 3 cycles after each MFA sample.
REQ-032 Byte read at 0x11 after REQ-031 -> DataOut=0x000000BE.
- Then byte write 0x55 at 0x12 and word read at 0x10 -> 0xDE55BEEF.
REQ-033 WAIT_STATES=0: MFA high -> MFC=1 on the next edge.
- MFA held high for 4 more cycles -> MFC stays 1, no second access.
- MFA low -> MFC=0 on the following edge.
REQ-034 Reset pulsed mid-WAIT of a word write of 0x12345678 to 0x20 -> MFC=0 immediately.
- A subsequent read at 0x20 SHALL return the prior contents.
REQ-035 MEM_ALIGN_CHECK_EN defined: word write to 0x21 -> MFC=1 and Error=1, and memory at 0x20 unchanged.
- Undefined: the same write SHALL update 0x20, with Error=0.
